// File: rtl/msg_fifo_arbiter.sv
// Round-robin arbiter that serialises producer messages into the shared 32-bit
// message FIFO as atomic header + 2-word bursts, dropping messages when room is short.
module msg_fifo_arbiter #(
  parameter int          NUM_REQ    = 5,
  parameter int          FIFO_DEPTH = 256,
  parameter int          USEDW_W    = 8,
  parameter logic [15:0] HDR_TAG    = 16'h4242
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [NUM_REQ*64-1:0]  req_data,
  output logic [NUM_REQ-1:0]     ack,
  output logic                   ack_dropped,
  input  logic [USEDW_W-1:0]     fifo_usedw,
  output logic                   fifo_wrreq,
  output logic [31:0]            fifo_data,
  output logic [15:0]            drop_count,
  output logic                   busy
);

  localparam int          IDX_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [31:0] ROOM_LIMIT = 32'(FIFO_DEPTH - 3);

  typedef enum logic [2:0] {IDLE, HDR, W0, W1, DROP} state_t;

  state_t             state, state_n;
  logic [IDX_W-1:0]   ptr, ptr_n;
  logic [IDX_W-1:0]   winner, winner_n;
  logic [IDX_W-1:0]   pick;
  logic               found;
  logic               room;
  logic [31:0]        word0, word0_n;
  logic [31:0]        word1, word1_n;
  logic [31:0]        fifo_data_n;
  logic               fifo_wrreq_n;
  logic [NUM_REQ-1:0] ack_n;
  logic               ack_dropped_n;
  logic [15:0]        drop_count_n;
  logic [63:0]        slots [NUM_REQ];

  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] v);
    if (int'(v) == NUM_REQ - 1) return '0;
    return v + IDX_W'(1);
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_slot
    assign slots[g] = req_data[g*64 +: 64];
  end

  // Free space only grows while a burst is in flight, so one check in IDLE suffices.
  assign room = (32'(fifo_usedw) < ROOM_LIMIT);

  always_comb begin
    logic [IDX_W-1:0] cand;
    cand  = ptr;
    found = 1'b0;
    pick  = ptr;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && req[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
      cand = next_idx(cand);
    end
  end

  always_comb begin
    state_n       = state;
    ptr_n         = ptr;
    winner_n      = winner;
    word0_n       = word0;
    word1_n       = word1;
    fifo_data_n   = fifo_data;
    fifo_wrreq_n  = 1'b0;
    ack_n         = '0;
    ack_dropped_n = 1'b0;
    drop_count_n  = drop_count;

    case (state)
      IDLE: begin
        if (enable && found) begin
          winner_n = pick;
          if (room) begin
            state_n      = HDR;
            word0_n      = slots[pick][63:32];
            word1_n      = slots[pick][31:0];
            fifo_wrreq_n = 1'b1;
            fifo_data_n  = {HDR_TAG, 8'h00, 8'(pick)};
          end else begin
            state_n       = DROP;
            ack_n[pick]   = 1'b1;
            ack_dropped_n = 1'b1;
            drop_count_n  = sat_inc(drop_count);
          end
        end
      end
      HDR: begin
        state_n      = W0;
        fifo_wrreq_n = 1'b1;
        fifo_data_n  = word0;
      end
      W0: begin
        state_n       = W1;
        fifo_wrreq_n  = 1'b1;
        fifo_data_n   = word1;
        ack_n[winner] = 1'b1;
      end
      W1: begin
        state_n = IDLE;
        ptr_n   = next_idx(winner);
      end
      DROP: begin
        state_n = IDLE;
        ptr_n   = next_idx(winner);
      end
      default: state_n = IDLE;
    endcase
  end

  // Outputs are registered together with the state they belong to.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      ptr         <= '0;
      winner      <= '0;
      word0       <= '0;
      word1       <= '0;
      fifo_data   <= '0;
      fifo_wrreq  <= 1'b0;
      ack         <= '0;
      ack_dropped <= 1'b0;
      drop_count  <= '0;
      busy        <= 1'b0;
    end else begin
      state       <= state_n;
      ptr         <= ptr_n;
      winner      <= winner_n;
      word0       <= word0_n;
      word1       <= word1_n;
      fifo_data   <= fifo_data_n;
      fifo_wrreq  <= fifo_wrreq_n;
      ack         <= ack_n;
      ack_dropped <= ack_dropped_n;
      drop_count  <= drop_count_n;
      busy        <= (state_n != IDLE);
    end
  end

endmodule

// File: doc/msg_fifo_arbiter.md
Name: msg_fifo_arbiter

Overview:
Shares the single 32-bit message FIFO, which feeds the CPU over the Avalon-MM slave, between several message producers. Producers include the per-colour bounding-box reporters and future sources such as distance or status messages. The block grants producers round-robin and writes each granted message as an atomic 3-word burst: a header followed by 2 payload words. It checks FIFO room before granting. A message with insufficient room is dropped and counted; the FIFO never overflows.

Parameters:
NUM_REQ, 5, number of requesters (1..8)
FIFO_DEPTH, 256, message FIFO depth in words
USEDW_W, 8, width of the FIFO used-word count
HDR_TAG, 16'h4242, upper 16 bits of every header word

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
enable  in  1  allows new grants; a message already in progress always completes
req  in  NUM_REQ  per-requester message request, level; held until ack
req_data  in  NUM_REQ*64  per-requester payload; slice i = {word0[63:32], word1[31:0]}; stable while req[i] is high
ack  out  NUM_REQ  one-cycle pulse: message i written or dropped
ack_dropped  out  1  valid with ack; 1 = message was dropped for lack of space
fifo_usedw  in  USEDW_W  FIFO fill level
fifo_wrreq  out  1  FIFO write strobe
fifo_data  out  32  FIFO write word
drop_count  out  16  number of dropped messages, saturating
busy  out  1  high whenever state != IDLE

Behaviour:
- Outputs: all registered (Moore).
- Reset, applied at any time including mid-burst:
  - state=IDLE; fifo_wrreq=0, fifo_data=0, ack=0, ack_dropped=0, drop_count=0, busy=0.
  - Round-robin pointer=0; latched payload=0.
  - Words of a partial burst already in the FIFO are not retracted; the system flushes the FIFO separately.
- States: IDLE, HDR, W0, W1, DROP.
- IDLE, when enable=1 and req!=0:
  - Winner = first set bit of req, scanning from the pointer upward with wrap at NUM_REQ-1→0.
  - Room check: fifo_usedw < FIFO_DEPTH-3 → latch req_data[winner] and the winner index; go to HDR.
  - Otherwise → go to DROP.
- IDLE, when enable=0 or req=0: stay in IDLE; no outputs change except ack and ack_dropped returning to 0.
- HDR: fifo_wrreq=1, fifo_data={HDR_TAG, 8'h00, 8'(winner)}.
- W0: fifo_wrreq=1, fifo_data=latched word0.
- W1: fifo_wrreq=1, fifo_data=latched word1; ack[winner]=1, ack_dropped=0.
- DROP: ack[winner]=1, ack_dropped=1; drop_count increments, saturating at 16'hFFFF; no FIFO write.
- Leaving W1 or DROP: return to IDLE; pointer = winner+1, wrapping to 0 after NUM_REQ-1.
- Timing:
  - Request seen in IDLE in cycle n → HDR write in n+1, W0 in n+2, W1 plus ack in n+3, IDLE in n+4.
  - Back-to-back requests are serviced once every 4 cycles.
  - A drop takes 2 cycles: ack in n+1, IDLE in n+2.
- Requester protocol: a requester deasserts req in the cycle after ack. The arbiter samples req only in IDLE and never in the ack cycle, so a registered requester cannot be double-granted.
- fifo_usedw is sampled only in IDLE. This block is the sole FIFO writer, so free space can only grow during a burst. A CPU read concurrent with the room check is harmless because the check is conservative.
- Boundary: fifo_usedw = FIFO_DEPTH-4 → grant. fifo_usedw = FIFO_DEPTH-3 → drop.
- enable falling mid-burst: the burst completes; no new grant until enable returns to 1.
- A req bit deasserting before grant: ignored; no ack is issued.
- At most one ack bit is high in any cycle. fifo_wrreq is never high outside HDR, W0 and W1.

Test Plan:
- Single request: req=5'b00100, data={32'h00AA_00BB, 32'h0011_0022}, usedw=0.
  → FIFO words 32'h4242_0002, 32'h00AA_00BB, 32'h0011_0022 on consecutive cycles; ack=5'b00100 coincident with the 3rd word; ack_dropped=0.
- Round-robin: all 5 requesters held high, each clearing req on its ack.
  → Header indices 0,1,2,3,4 in order; 15 FIFO writes total; each burst starts 4 cycles after the previous one.
- Fairness after wrap: pointer=3, req=5'b01001.
  → Requester 3 is granted first, then requester 0.
- Room boundary:
  - usedw=252 with req → a 3-word burst is written.
  - usedw=253 → no fifo_wrreq; ack with ack_dropped=1; drop_count=1.
  - 65540 forced drops → drop_count=16'hFFFF.
- enable=0 during W0 → the burst finishes through W1; a pending request on another channel is not granted until enable=1.
- Reset asserted in W0 → next cycle: fifo_wrreq=0, ack=0, busy=0, drop_count=0; after release, req on channel 0 is granted first (pointer=0).
